// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_arb_pkg
// Purpose  : Shared widths and response-owner encoding for simple_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

endpackage
`default_nettype wire

// File: rtl/simple_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : simple_mem_arbiter_if
// Purpose   : Fetch, LSU and memory-side signals of simple_mem_arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface simple_mem_arbiter_if;
   import mem_arb_pkg::*;

   logic            if_req_i;
   logic [XLEN-1:0] if_addr_i;
   logic            if_kill_i;
   logic            if_gnt_o;
   logic            if_rvalid_o;
   logic [XLEN-1:0] if_rdata_o;

   logic            ls_req_i;
   logic            ls_we_i;
   logic [BE_W-1:0] ls_be_i;
   logic [XLEN-1:0] ls_addr_i;
   logic [XLEN-1:0] ls_wdata_i;
   logic            ls_gnt_o;
   logic            ls_rvalid_o;
   logic [XLEN-1:0] ls_rdata_o;

   logic            mem_req_o;
   logic            mem_we_o;
   logic [BE_W-1:0] mem_be_o;
   logic [XLEN-1:0] mem_addr_o;
   logic [XLEN-1:0] mem_wdata_o;
   logic [XLEN-1:0] mem_rdata_i;

   // Arbiter view
   modport slave (
      input  if_req_i, if_addr_i, if_kill_i,
      output if_gnt_o, if_rvalid_o, if_rdata_o,
      input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   // Requesters plus memory model view
   modport master (
      output if_req_i, if_addr_i, if_kill_i,
      input  if_gnt_o, if_rvalid_o, if_rdata_o,
      output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
      input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with enable and clear that holds at MAX.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int unsigned    W   = 8,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : simple_mem_arbiter
// Purpose  : Shares one single-port memory between fetch and LSU with LSU
//            priority, fetch anti-starvation and 1-cycle response steering.
// Options  : SIMPLE_MEM_ARB_PERF_EN adds saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module simple_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned PERF_W     = 32
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
`ifdef SIMPLE_MEM_ARB_PERF_EN
   output logic [PERF_W-1:0]     perf_conflict_o,
   output logic [PERF_W-1:0]     perf_if_gnt_o,
   output logic [PERF_W-1:0]     perf_ls_gnt_o,
`endif
   simple_mem_arbiter_if.slave   bus
);

   localparam int unsigned c_STARVE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

   if (STARVE_MAX == 0) begin : g_bad_starve_max
      $error("simple_mem_arbiter: STARVE_MAX must be >= 1");
   end

   logic [c_STARVE_W-1:0] starve_cnt;
   logic                  w_if_win;
   logic                  w_if_gnt;
   logic                  w_ls_gnt;
   logic                  w_if_rvalid;
   logic                  w_ls_rvalid;

   owner_e owner_q, owner_d;
   logic   ls_rd_q, ls_rd_d;
   logic   kill_q,  kill_d;

   // Grants are gated by reset so nothing leaks out while rstn_i is low
   always_comb begin
      w_if_win = ~bus.ls_req_i | (starve_cnt == c_STARVE_MAX);
      w_if_gnt = rstn_i & bus.if_req_i & w_if_win;
      w_ls_gnt = rstn_i & bus.ls_req_i & ~w_if_gnt;
   end

   always_comb begin
      bus.mem_we_o    = 1'b0;
      bus.mem_be_o    = '0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      if (w_if_gnt) begin
         bus.mem_be_o   = '1;
         bus.mem_addr_o = bus.if_addr_i;
      end else if (w_ls_gnt) begin
         bus.mem_we_o    = bus.ls_we_i;
         bus.mem_be_o    = bus.ls_be_i;
         bus.mem_addr_o  = bus.ls_addr_i;
         bus.mem_wdata_o = bus.ls_wdata_i;
      end
   end

   assign bus.mem_req_o = w_if_gnt | w_ls_gnt;
   assign bus.if_gnt_o  = w_if_gnt;
   assign bus.ls_gnt_o  = w_ls_gnt;

   sat_counter #(
      .W   (c_STARVE_W),
      .MAX (c_STARVE_MAX)
   ) u_starve_cnt (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .inc_i  (bus.if_req_i & ~w_if_gnt),
      .clr_i  (~bus.if_req_i | w_if_gnt),
      .cnt_o  (starve_cnt)
   );

   // Kill is captured every cycle: a kill in the grant cycle drops the response
   always_comb begin
      owner_d = OWN_NONE;
      ls_rd_d = 1'b0;
      kill_d  = bus.if_kill_i;
      if (w_if_gnt) begin
         owner_d = OWN_IF;
      end else if (w_ls_gnt) begin
         owner_d = OWN_LS;
         ls_rd_d = ~bus.ls_we_i;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         owner_q <= OWN_NONE;
         ls_rd_q <= 1'b0;
         kill_q  <= 1'b0;
      end else begin
         owner_q <= owner_d;
         ls_rd_q <= ls_rd_d;
         kill_q  <= kill_d;
      end
   end

   always_comb begin
      w_if_rvalid = (owner_q == OWN_IF) & ~kill_q & ~bus.if_kill_i;
      w_ls_rvalid = (owner_q == OWN_LS);
   end

   assign bus.if_rvalid_o = w_if_rvalid;
   assign bus.if_rdata_o  = w_if_rvalid ? bus.mem_rdata_i : '0;
   assign bus.ls_rvalid_o = w_ls_rvalid;
   assign bus.ls_rdata_o  = (w_ls_rvalid && ls_rd_q) ? bus.mem_rdata_i : '0;

`ifdef SIMPLE_MEM_ARB_PERF_EN
   sat_counter #(.W(PERF_W)) u_perf_conflict (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .inc_i  (bus.if_req_i & bus.ls_req_i),
      .clr_i  (1'b0),
      .cnt_o  (perf_conflict_o)
   );

   sat_counter #(.W(PERF_W)) u_perf_if_gnt (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .inc_i  (w_if_gnt),
      .clr_i  (1'b0),
      .cnt_o  (perf_if_gnt_o)
   );

   sat_counter #(.W(PERF_W)) u_perf_ls_gnt (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .inc_i  (w_ls_gnt),
      .clr_i  (1'b0),
      .cnt_o  (perf_ls_gnt_o)
   );
`else
   if (PERF_W == 0) begin : g_bad_perf_w
      $error("simple_mem_arbiter: PERF_W must be >= 1");
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_mem_arbiter
// Purpose  : Self-checking bench: directed vector table, reset/kill corner
//            sequences and randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_mem_arbiter;

   localparam int STARVE_MAX = 4;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        if_kill;
      logic        ls_req;
      logic        ls_we;
      logic [3:0]  ls_be;
      logic [31:0] ls_addr;
      logic [31:0] ls_wdata;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic        ig;
      logic        lg;
      logic        irv;
      logic [31:0] ird;
      logic        lrv;
      logic [31:0] lrd;
   } vec_t;

   logic clk = 1'b0;
   logic rstn;
   logic mem_init;
   always #5 clk = ~clk;

   simple_mem_arbiter_if bus();

`ifdef SIMPLE_MEM_ARB_PERF_EN
   logic [31:0] perf_conflict, perf_if_gnt, perf_ls_gnt;
`endif

   simple_mem_arbiter #(
      .STARVE_MAX (STARVE_MAX),
      .PERF_W     (32)
   ) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
`ifdef SIMPLE_MEM_ARB_PERF_EN
      .perf_conflict_o (perf_conflict),
      .perf_if_gnt_o   (perf_if_gnt),
      .perf_ls_gnt_o   (perf_ls_gnt),
`endif
      .bus             (bus)
   );

   // Environment memory: word k initialised to k, 1-cycle read latency
   logic [31:0] mem [256];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      end else if (bus.mem_req_o) begin
         bus.mem_rdata_i <= mem[bus.mem_addr_o[9:2]];
         if (bus.mem_we_o) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_be_o[b]) mem[bus.mem_addr_o[9:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;
   bit check_model = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] ref_mem [256];
   int          starve;
   bit          pend_v, pend_if, pend_rd, pend_killed;
   logic [31:0] pend_data;
   logic        exp_ig, exp_lg, exp_irv, exp_lrv;
   logic [31:0] exp_ird, exp_lrd;

   task automatic model_reset();
      starve = 0;
      pend_v = 1'b0;
   endtask

   task automatic model_expect(input stim_t s);
      exp_ig  = s.if_req && (!s.ls_req || starve == STARVE_MAX);
      exp_lg  = s.ls_req && !exp_ig;
      exp_irv = 1'b0; exp_ird = '0;
      exp_lrv = 1'b0; exp_lrd = '0;
      if (pend_v && pend_if) begin
         exp_irv = !pend_killed && !s.if_kill;
         exp_ird = exp_irv ? pend_data : 32'h0;
      end else if (pend_v) begin
         exp_lrv = 1'b1;
         exp_lrd = pend_rd ? pend_data : 32'h0;
      end
   endtask

   task automatic model_commit(input stim_t s);
      logic [7:0] idx;
      idx         = exp_ig ? s.if_addr[9:2] : s.ls_addr[9:2];
      pend_v      = exp_ig || exp_lg;
      pend_if     = exp_ig;
      pend_rd     = exp_ig || (exp_lg && !s.ls_we);
      pend_data   = ref_mem[idx];
      pend_killed = s.if_kill;
      if (exp_lg && s.ls_we)
         for (int b = 0; b < 4; b++)
            if (s.ls_be[b]) ref_mem[idx][8*b +: 8] = s.ls_wdata[8*b +: 8];
      if (s.if_req && !exp_ig) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      else                     starve = 0;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic apply(input stim_t s);
      bus.if_req_i   = s.if_req;
      bus.if_addr_i  = s.if_addr;
      bus.if_kill_i  = s.if_kill;
      bus.ls_req_i   = s.ls_req;
      bus.ls_we_i    = s.ls_we;
      bus.ls_be_i    = s.ls_be;
      bus.ls_addr_i  = s.ls_addr;
      bus.ls_wdata_i = s.ls_wdata;
   endtask

   function automatic stim_t mks(logic ir, logic [31:0] ia, logic k, logic lr, logic we,
                                 logic [3:0] be, logic [31:0] la, logic [31:0] wd);
      stim_t s;
      s.if_req = ir; s.if_addr = ia; s.if_kill = k;
      s.ls_req = lr; s.ls_we = we; s.ls_be = be; s.ls_addr = la; s.ls_wdata = wd;
      return s;
   endfunction

   function automatic vec_t mk(stim_t s, logic ig, logic lg, logic irv, logic [31:0] ird,
                               logic lrv, logic [31:0] lrd);
      vec_t v;
      v.s = s; v.ig = ig; v.lg = lg; v.irv = irv; v.ird = ird; v.lrv = lrv; v.lrd = lrd;
      return v;
   endfunction

   // One cycle: drive at negedge, sample 1ns later, advance the model
   task automatic step(input stim_t s);
      @(negedge clk);
      apply(s);
      #1;
      model_expect(s);
      if (check_model) begin
         chk("m_if_gnt",    32'(bus.if_gnt_o),    32'(exp_ig));
         chk("m_ls_gnt",    32'(bus.ls_gnt_o),    32'(exp_lg));
         chk("m_mem_req",   32'(bus.mem_req_o),   32'(exp_ig | exp_lg));
         if (exp_ig || exp_lg) begin
            chk("m_mem_we",    32'(bus.mem_we_o),  32'(exp_lg & s.ls_we));
            chk("m_mem_be",    32'(bus.mem_be_o),  exp_ig ? 32'hF : 32'(s.ls_be));
            chk("m_mem_addr",  bus.mem_addr_o,     exp_ig ? s.if_addr : s.ls_addr);
            chk("m_mem_wdata", bus.mem_wdata_o,    exp_ig ? 32'h0 : s.ls_wdata);
         end
         chk("m_if_rvalid", 32'(bus.if_rvalid_o), 32'(exp_irv));
         chk("m_if_rdata",  bus.if_rdata_o,       exp_ird);
         chk("m_ls_rvalid", 32'(bus.ls_rvalid_o), 32'(exp_lrv));
         chk("m_ls_rdata",  bus.ls_rdata_o,       exp_lrd);
      end
      model_commit(s);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"},    32'(bus.if_gnt_o),    32'h0);
      chk({tag, "_ls_gnt"},    32'(bus.ls_gnt_o),    32'h0);
      chk({tag, "_mem_req"},   32'(bus.mem_req_o),   32'h0);
      chk({tag, "_mem_we"},    32'(bus.mem_we_o),    32'h0);
      chk({tag, "_mem_be"},    32'(bus.mem_be_o),    32'h0);
      chk({tag, "_mem_addr"},  bus.mem_addr_o,       32'h0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata_o,      32'h0);
      chk({tag, "_if_rvalid"}, 32'(bus.if_rvalid_o), 32'h0);
      chk({tag, "_if_rdata"},  bus.if_rdata_o,       32'h0);
      chk({tag, "_ls_rvalid"}, 32'(bus.ls_rvalid_o), 32'h0);
      chk({tag, "_ls_rdata"},  bus.ls_rdata_o,       32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
      $fatal(1);
   end

   initial begin
      vec_t  tbl [24];
      stim_t idle, both, cur;

      idle = mks(0, 0, 0, 0, 0, 0, 0, 0);
      both = mks(1, 32'hC, 0, 1, 0, 0, 32'h8, 0);
      // fetch stream, LSU write/read, conflict starvation, fetch kill
      tbl[0]  = mk(mks(1, 32'h0, 0, 0, 0, 0, 0, 0),                       1, 0, 0, 0,     0, 0);
      tbl[1]  = mk(mks(1, 32'h4, 0, 0, 0, 0, 0, 0),                       1, 0, 1, 0,     0, 0);
      tbl[2]  = mk(mks(1, 32'h8, 0, 0, 0, 0, 0, 0),                       1, 0, 1, 1,     0, 0);
      tbl[3]  = mk(idle,                                                   0, 0, 1, 2,     0, 0);
      tbl[4]  = mk(mks(0, 0, 0, 1, 1, 4'b0011, 32'h40, 32'hDEADBEEF),     0, 1, 0, 0,     0, 0);
      tbl[5]  = mk(mks(0, 0, 0, 1, 0, 4'h0, 32'h40, 0),                   0, 1, 0, 0,     1, 0);
      tbl[6]  = mk(idle,                                                   0, 0, 0, 0,     1, 32'h0000BEEF);
      tbl[7]  = mk(both,                                                   0, 1, 0, 0,     0, 0);
      tbl[8]  = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[9]  = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[10] = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[11] = mk(both,                                                   1, 0, 0, 0,     1, 2);
      tbl[12] = mk(both,                                                   0, 1, 1, 3,     0, 0);
      tbl[13] = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[14] = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[15] = mk(both,                                                   0, 1, 0, 0,     1, 2);
      tbl[16] = mk(both,                                                   1, 0, 0, 0,     1, 2);
      tbl[17] = mk(mks(0, 0, 0, 1, 0, 0, 32'h8, 0),                       0, 1, 1, 3,     0, 0);
      tbl[18] = mk(mks(1, 32'h0, 0, 0, 0, 0, 0, 0),                       1, 0, 0, 0,     1, 2);
      tbl[19] = mk(mks(0, 0, 1, 0, 0, 0, 0, 0),                           0, 0, 0, 0,     0, 0);
      tbl[20] = mk(mks(1, 32'h100, 0, 0, 0, 0, 0, 0),                     1, 0, 0, 0,     0, 0);
      tbl[21] = mk(idle,                                                   0, 0, 1, 32'h40, 0, 0);
      tbl[22] = mk(mks(1, 32'h4, 1, 0, 0, 0, 0, 0),                       1, 0, 0, 0,     0, 0);
      tbl[23] = mk(idle,                                                   0, 0, 0, 0,     0, 0);

      // Reset with requests pending: everything must stay quiet
      rstn     = 1'b0;
      mem_init = 1'b1;
      apply(mks(1, 32'h8, 0, 1, 1, 4'hF, 32'h10, 32'h1234));
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_all_zero("rst");
      @(negedge clk);
      apply(idle);
      mem_init = 1'b0;
      rstn     = 1'b1;

      for (int i = 0; i < 24; i++) begin
         step(tbl[i].s);
         chk($sformatf("row%0d_if_gnt", i),    32'(bus.if_gnt_o),    32'(tbl[i].ig));
         chk($sformatf("row%0d_ls_gnt", i),    32'(bus.ls_gnt_o),    32'(tbl[i].lg));
         chk($sformatf("row%0d_mem_req", i),   32'(bus.mem_req_o),   32'(tbl[i].ig | tbl[i].lg));
         chk($sformatf("row%0d_if_rvalid", i), 32'(bus.if_rvalid_o), 32'(tbl[i].irv));
         chk($sformatf("row%0d_if_rdata", i),  bus.if_rdata_o,       tbl[i].ird);
         chk($sformatf("row%0d_ls_rvalid", i), 32'(bus.ls_rvalid_o), 32'(tbl[i].lrv));
         chk($sformatf("row%0d_ls_rdata", i),  bus.ls_rdata_o,       tbl[i].lrd);
      end

      // Reset asserted with a fetch read in flight
      step(mks(1, 32'h8, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      apply(mks(1, 32'h8, 0, 1, 0, 4'hF, 32'h20, 0));
      rstn = 1'b0;
      #1;
      chk_all_zero("rst_inflight");
      model_reset();
      repeat (2) @(negedge clk);
      apply(idle);
      rstn = 1'b1;
      check_model = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(idle);
         chk("post_rst_if_rvalid", 32'(bus.if_rvalid_o), 32'h0);
         chk("post_rst_ls_rvalid", 32'(bus.ls_rvalid_o), 32'h0);
      end

      // Ten conflict cycles right after reset
      for (int i = 0; i < 10; i++) step(mks(1, 32'h10, 0, 1, 0, 4'hF, 32'h14, 0));
      step(idle);
`ifdef SIMPLE_MEM_ARB_PERF_EN
      chk("perf_conflict", perf_conflict, 32'd10);
      chk("perf_gnt_sum",  perf_if_gnt + perf_ls_gnt, 32'd10);
      chk("perf_if_gnt",   perf_if_gnt, 32'd2);
`endif

      // Randomized traffic; requesters hold until the model says granted
      cur = idle;
      for (int i = 0; i < 400; i++) begin
         if (!cur.if_req && $urandom_range(0, 2) != 0) begin
            cur.if_req  = 1'b1;
            cur.if_addr = 32'($urandom_range(0, 255)) << 2;
         end
         if (!cur.ls_req && $urandom_range(0, 2) != 0) begin
            cur.ls_req   = 1'b1;
            cur.ls_we    = 1'($urandom_range(0, 1));
            cur.ls_be    = 4'($urandom_range(0, 15));
            cur.ls_addr  = 32'($urandom_range(0, 255)) << 2;
            cur.ls_wdata = $urandom;
         end
         cur.if_kill = ($urandom_range(0, 7) == 0);
         step(cur);
         if (exp_ig) cur.if_req = 1'b0;
         if (exp_lg) cur.ls_req = 1'b0;
      end
      step(idle);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
